// File: rtl/ifetch_ooo6502.sv
// 6502 instruction fetch: a linear byte stream is split into instructions and queued for the decoder.
// Define IFETCH_RESET_VECTOR_EN to start from the FFFC/FFFD reset vector instead of RESET_PC.
module ifetch_ooo6502 #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr_o,
  output logic        rd_o,
  input  logic [7:0]  din_i,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_op,
  output logic [15:0] instr_operand,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 42;

`ifdef IFETCH_RESET_VECTOR_EN
  localparam logic [2:0] VEC_LO = 3'd0;
  localparam logic [2:0] VEC_HI = 3'd1;
`endif
  localparam logic [2:0] OPC    = 3'd2;
  localparam logic [2:0] OPR1   = 3'd3;
  localparam logic [2:0] OPR2   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   ipc_q, ipc_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    b2_q, b2_d;
  logic [1:0]    len_q, len_d;
`ifdef IFETCH_RESET_VECTOR_EN
  logic [7:0]    vec_lo_q, vec_lo_d;
`endif
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push, pop, rd_c;
  logic [EW-1:0] entry;
  logic [15:0]   pc_cur, addr_c;
  logic [1:0]    opc_len;
  logic [EW-1:0] head;

  // Opcode length from the 6502 aaabbbcc layout.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] bbb;
    bbb = op[4:2];
    op_len = 2'd1;
    case (op[1:0])
      2'b01: op_len = (bbb == 3'd3 || bbb == 3'd6 || bbb == 3'd7) ? 2'd3 : 2'd2;
      2'b10: begin
        if (bbb == 3'd3 || bbb == 3'd7)                     op_len = 2'd3;
        else if (bbb == 3'd0 || bbb == 3'd1 || bbb == 3'd5) op_len = 2'd2;
        else                                                op_len = 2'd1;
      end
      2'b00: begin
        if (op == 8'h20)                      op_len = 2'd3;
        else if (op == 8'h00)                 op_len = 2'd2;
        else if (op == 8'h40 || op == 8'h60)  op_len = 2'd1;
        else begin
          case (bbb)
            3'd0, 3'd1, 3'd4, 3'd5: op_len = 2'd2;
            3'd3, 3'd7:             op_len = 2'd3;
            default:                op_len = 2'd1;
          endcase
        end
      end
      default: op_len = 2'd1;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    fetch_pc_d = fetch_pc_q;
    ipc_d      = ipc_q;
    op_d       = op_q;
    b2_d       = b2_q;
    len_d      = len_q;
`ifdef IFETCH_RESET_VECTOR_EN
    vec_lo_d   = vec_lo_q;
`endif
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    entry      = '0;
    pc_cur     = fetch_pc_q;
    addr_c     = 16'h0000;
    opc_len    = op_len(din_i);

    // Consume the byte requested last cycle.
    if (inflight_q) begin
      case (state_q)
`ifdef IFETCH_RESET_VECTOR_EN
        VEC_LO: begin
          vec_lo_d = din_i;
          state_d  = VEC_HI;
        end
        VEC_HI: begin
          pc_cur  = {din_i, vec_lo_q};
          state_d = OPC;
        end
`endif
        OPC: begin
          op_d  = din_i;
          len_d = opc_len;
          if (opc_len == 2'd1) begin
            push  = 1'b1;
            entry = {din_i, 16'h0000, 2'd1, ipc_q};
          end else begin
            state_d = OPR1;
          end
        end
        OPR1: begin
          b2_d = din_i;
          if (len_q == 2'd2) begin
            push    = 1'b1;
            entry   = {op_q, 8'h00, din_i, 2'd2, ipc_q};
            state_d = OPC;
          end else begin
            state_d = OPR2;
          end
        end
        OPR2: begin
          push    = 1'b1;
          entry   = {op_q, din_i, b2_q, 2'd3, ipc_q};
          state_d = OPC;
        end
        default: state_d = OPC;
      endcase
    end

    pop = (count_q != '0) && instr_ready;

    // An opcode read reserves a queue slot; a same-cycle pop is not credited, keeping instr_ready off the read path.
    rd_c = !rst && !redirect_valid &&
           ((state_d != OPC) || ((count_q + CW'(push)) < CW'(DEPTH)));
    if (rd_c) begin
      addr_c     = pc_cur;
      fetch_pc_d = pc_cur + 16'd1;
      if (state_d == OPC) ipc_d = pc_cur;
    end else begin
      fetch_pc_d = pc_cur;
    end
    inflight_d = rd_c;

    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect_valid) begin
      state_d    = OPC;
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef IFETCH_RESET_VECTOR_EN
      state_q    <= VEC_LO;
      fetch_pc_q <= 16'hFFFC;
      vec_lo_q   <= 8'h00;
`else
      state_q    <= OPC;
      fetch_pc_q <= RESET_PC;
`endif
      inflight_q <= 1'b0;
      ipc_q      <= 16'h0000;
      op_q       <= 8'h00;
      b2_q       <= 8'h00;
      len_q      <= 2'd0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
`ifdef IFETCH_RESET_VECTOR_EN
      vec_lo_q   <= vec_lo_d;
`endif
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
      op_q       <= op_d;
      b2_q       <= b2_d;
      len_q      <= len_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rd_o          = rd_c;
  assign addr_o        = addr_c;
  assign instr_valid   = (count_q != '0);
  assign instr_op      = head[41:34];
  assign instr_operand = head[33:18];
  assign instr_len     = head[17:16];
  assign instr_pc      = head[15:0];

endmodule

// File: tb/tb_ifetch_ooo6502.sv
// Directed bench for ifetch_ooo6502 with a one-cycle-latency memory and a scoreboard of expected queue entries.
// Covers both builds of IFETCH_RESET_VECTOR_EN.
module tb_ifetch_ooo6502;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
    logic [15:0] pc;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [15:0] addr_o;
  logic        rd_o;
  logic [7:0]  din_i;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic [15:0] instr_operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  logic [7:0]  mem [0:65535];
  logic        pend;
  logic [15:0] paddr;
  int          nreads;
  int          checks;
  int          errors;
  ent_t        exp_q[$];
  ent_t        pe;

  ifetch_ooo6502 dut (
    .clk           (clk),
    .rst           (rst),
    .addr_o        (addr_o),
    .rd_o          (rd_o),
    .din_i         (din_i),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_operand (instr_operand),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_ent(input logic [7:0] op, input logic [15:0] opnd,
                            input logic [1:0] len, input logic [15:0] pc);
    ent_t e;
    e.op = op; e.opnd = opnd; e.len = len; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // One-cycle pop handshake, then let the freed slot refill.
  task automatic pulse_ready();
    tick(); instr_ready = 1'b1;
    sample();
    tick(); instr_ready = 1'b0;
    sample();
    tick();
    sample();
  endtask

  task automatic wait_stall(input string tag);
    int n;
    n = 0;
    while (rd_o !== 1'b0 && n < 30) begin
      tick(); sample(); n++;
    end
    chk(tag, 32'(rd_o), 32'd0);
  endtask

  // Memory: a request seen in one cycle returns its byte in the next.
  always @(negedge clk) begin
    pend  = rd_o;
    paddr = addr_o;
    if (rd_o === 1'b1) nreads++;
  end

  always @(posedge clk) begin
    #1;
    din_i = pend ? mem[paddr] : 8'h00;
  end

  // Scoreboard: every decoder handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=op_%h_pc_%h expected=no_entry", instr_op, instr_pc);
      end
      if (exp_q.size() != 0) begin
        pe = exp_q.pop_front();
        chk("pop_op",      32'(instr_op),      32'(pe.op));
        chk("pop_operand", 32'(instr_operand), 32'(pe.opnd));
        chk("pop_len",     32'(instr_len),     32'(pe.len));
        chk("pop_pc",      32'(instr_pc),      32'(pe.pc));
      end
    end
  end

  initial begin
    checks = 0; errors = 0; nreads = 0;
    pend = 1'b0; paddr = 16'h0000; din_i = 8'h00;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h05; mem[16'h0202] = 8'hEA;
    mem[16'h0203] = 8'h4C; mem[16'h0204] = 8'h34; mem[16'h0205] = 8'h12;
    mem[16'h0300] = 8'h20; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h90;
    mem[16'h8000] = 8'hA2; mem[16'h8001] = 8'h7F; mem[16'h8002] = 8'h60;
    mem[16'h8003] = 8'h8D; mem[16'h8004] = 8'h00; mem[16'h8005] = 8'h02;
    mem[16'h8006] = 8'h0A;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;

    // Reset values
    tick(); tick(); tick();
    sample();
    chk("reset_rd_o",        32'(rd_o),        32'd0);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    chk("reset_addr_o",      32'(addr_o),      32'd0);

    tick(); rst = 1'b0; nreads = 0;
`ifdef IFETCH_RESET_VECTOR_EN
    sample();
    chk("vec_lo_rd_o", 32'(rd_o),   32'd1);
    chk("vec_lo_addr", 32'(addr_o), 32'hFFFC);
    tick(); sample();
    chk("vec_hi_rd_o", 32'(rd_o),   32'd1);
    chk("vec_hi_addr", 32'(addr_o), 32'hFFFD);
    tick(); sample();
    chk("vec_opc_rd_o", 32'(rd_o),   32'd1);
    chk("vec_opc_addr", 32'(addr_o), 32'hC000);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0200; nreads = 0;
    sample();
    chk("redir0200_rd_o", 32'(rd_o), 32'd0);
    tick(); redirect_valid = 1'b0;
    sample();
`else
    sample();
`endif
    chk("first_read_rd_o", 32'(rd_o),   32'd1);
    chk("first_read_addr", 32'(addr_o), 32'h0200);

    // Fill with the decoder stalled
    expect_ent(8'hA9, 16'h0005, 2'd2, 16'h0200);
    wait_stall("fill_stall_a");
    chk("reads_before_stall", 32'(nreads), 32'd7);
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      chk("stall_rd_o",   32'(rd_o),          32'd0);
      chk("stall_valid",  32'(instr_valid),   32'd1);
      chk("stall_op",     32'(instr_op),      32'h00A9);
      chk("stall_opnd",   32'(instr_operand), 32'h0005);
      chk("stall_pc",     32'(instr_pc),      32'h0200);
    end

    // Single-cycle ready: one pop, then exactly one opcode read the next cycle
    tick(); instr_ready = 1'b1;
    sample();
    chk("pulse_cycle_rd_o", 32'(rd_o), 32'd0);
    tick(); instr_ready = 1'b0;
    sample();
    chk("post_pulse_rd_o", 32'(rd_o),   32'd1);
    chk("post_pulse_addr", 32'(addr_o), 32'h0207);
    tick(); sample();
    chk("refill_stall_rd_o", 32'(rd_o), 32'd0);

    // Drain with ready held high
    tick(); instr_ready = 1'b1;
    expect_ent(8'hEA, 16'h0000, 2'd1, 16'h0202);
    expect_ent(8'h4C, 16'h1234, 2'd3, 16'h0203);
    for (int i = 0; i < 6; i++) expect_ent(8'hEA, 16'h0000, 2'd1, 16'(16'h0206 + i));
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i > 0) chk("drain_rd_o", 32'(rd_o), 32'd1);
      tick();
    end
    instr_ready = 1'b0;

    // Redirect, then redirect again while an operand byte arrives
    redirect_valid = 1'b1; redirect_pc = 16'h0300;
    sample();
    chk("redir_rd_o", 32'(rd_o), 32'd0);
    tick(); redirect_valid = 1'b0;
    sample();
    chk("redir_flush_valid", 32'(instr_valid), 32'd0);
    chk("redir_next_rd_o",   32'(rd_o),        32'd1);
    chk("redir_next_addr",   32'(addr_o),      32'h0300);
    tick(); sample();
    chk("opr1_read_addr", 32'(addr_o), 32'h0301);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h8000;
    expect_ent(8'hA2, 16'h007F, 2'd2, 16'h8000);
    expect_ent(8'h60, 16'h0000, 2'd1, 16'h8002);
    expect_ent(8'h8D, 16'h0200, 2'd3, 16'h8003);
    expect_ent(8'h0A, 16'h0000, 2'd1, 16'h8006);
    sample();
    chk("redir_opr_rd_o", 32'(rd_o), 32'd0);
    tick(); redirect_valid = 1'b0;
    sample();
    chk("redir_drop_valid", 32'(instr_valid), 32'd0);
    chk("redir_8000_rd_o",  32'(rd_o),        32'd1);
    chk("redir_8000_addr",  32'(addr_o),      32'h8000);
    wait_stall("fill_stall_c");
    for (int i = 0; i < 4; i++) pulse_ready();

    // Address wrap across FFFF
    tick(); redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    expect_ent(8'h20, 16'hABCD, 2'd3, 16'hFFFE);
    for (int i = 1; i < 4; i++) expect_ent(8'hEA, 16'h0000, 2'd1, 16'(i));
    sample();
    tick(); redirect_valid = 1'b0;
    sample();
    chk("wrap_opc_addr", 32'(addr_o), 32'hFFFE);
    tick(); sample();
    chk("wrap_opr1_addr", 32'(addr_o), 32'hFFFF);
    tick(); sample();
    chk("wrap_opr2_rd_o", 32'(rd_o),   32'd1);
    chk("wrap_opr2_addr", 32'(addr_o), 32'h0000);
    wait_stall("fill_stall_d");
    for (int i = 0; i < 4; i++) pulse_ready();

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ooo6502.md
IFETCH_OOO6502 -- requirements
Module: ifetch_ooo6502

Interface
REQ-001 Parameter DEPTH, default 4, sets the instruction queue entries (power of two, >= 2).
REQ-002 Parameter RESET_PC, default 16'h0200, is the start fetch address when the vector fetch is compiled out.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port addr_o, output, 16 bits: memory read address, meaningful when rd_o=1.
REQ-006 Port rd_o, output, 1 bit: memory read request.
REQ-007 Port din_i, input, 8 bits: read data, valid exactly one cycle after the request cycle.
REQ-008 Port redirect_valid, input, 1 bit: flush and restart fetch at a new address.
REQ-009 Port redirect_pc, input, 16 bits: the restart address.
REQ-010 Port instr_valid, output, 1 bit: the queue head holds an instruction.
REQ-011 Port instr_ready, input, 1 bit: the decoder accepts the head.
REQ-012 Port instr_op, output, 8 bits: the head opcode.
REQ-013 Port instr_operand, output, 16 bits: {byte3, byte2}; absent bytes read as zero.
REQ-014 Port instr_len, output, 2 bits: instruction length, 1 to 3.
REQ-015 Port instr_pc, output, 16 bits: address of the head opcode.

Function
REQ-016 The block SHALL fetch a linear byte stream, one outstanding read at most, and SHALL increment fetch_pc modulo 2^16 (FFFF wraps to 0000).
REQ-017 Opcode length SHALL be decoded combinationally from din_i in the arrival cycle, per the following rules.
- cc=01: bbb 011/110/111 give 3, else 2.
- cc=10: bbb 011/111 give 3; 000/001/101 give 2; else 1.
- cc=00: 20 gives 3; 00 gives 2; 40/60 give 1; bbb 000/001/100/101 give 2; 011/111 give 3; 010/110 give 1.
- cc=11: 1.
REQ-018 The state machine SHALL use the states VEC_LO, VEC_HI, OPC, OPR1 and OPR2; each state waits for its byte to arrive.
REQ-019 The read for the next needed byte SHALL be issued in the same cycle the previous byte arrives, sustaining 1 byte per cycle.
REQ-020 A completed instruction SHALL be pushed in its final-byte arrival cycle and SHALL be visible on instr_valid the next cycle.
- Example: a 1-byte instruction read in cycle N arrives in N+1 and is valid in N+2.
REQ-021 An opcode read SHALL be issued only if the post-cycle queue count is below DEPTH; otherwise the block stays in OPC with rd_o=0 until a pop frees an entry.
REQ-022 A pop SHALL occur when instr_valid and instr_ready are both high; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-023 The queue SHALL never overflow, and the head outputs SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 Redirect SHALL have priority over all other events. In the redirect cycle:
- a pop handshake that cycle SHALL complete;
- the queue and the partial instruction SHALL be flushed;
- any arriving byte SHALL be discarded;
- rd_o SHALL be 0;
- the state SHALL become OPC with fetch_pc=redirect_pc.
REQ-025 The first read after a redirect SHALL occur in the next cycle at redirect_pc; a redirect during VEC_LO or VEC_HI SHALL abort the vector fetch.

Reset
REQ-026 Reset SHALL force rd_o=0 and instr_valid=0, empty the queue, clear the in-flight flag, and force addr_o=0.
REQ-027 Reset SHALL set the state to VEC_LO (macro defined) or OPC with fetch_pc=RESET_PC (macro undefined).
REQ-028 A read in flight at reset assertion SHALL be ignored, and the first read SHALL occur in the first cycle after rst deasserts.

Configuration
REQ-029 Macro IFETCH_RESET_VECTOR_EN SHALL select the reset start address.
- Defined: the block reads FFFC then FFFD and starts fetching at {byte@FFFD, byte@FFFC}.
- Undefined: the VEC states are removed and fetching starts at RESET_PC.

Verification
REQ-030 Memory holds A9 05 EA at 0200 with the macro off and instr_ready=1. Required: entry {op A9, operand 0005, len 2, pc 0200}, then {EA, 0000, 1, 0202}, and rd_o high every cycle.
REQ-031 Memory holds 4C 34 12 at 0200. Required: {op 4C, operand 1234, len 3, pc 0200}, and the next read address is 0203.
REQ-032 instr_ready=0 with a stream of EA bytes and DEPTH=4. Required: exactly 4 entries queued, rd_o=0 thereafter, and one read issued in the cycle after instr_ready pulses high for one cycle.
REQ-033 redirect_valid=1 with redirect_pc=8000 while an operand byte is arriving. Required: that byte is dropped, instr_valid=0 next cycle, and addr_o=8000 with rd_o=1 next cycle.
REQ-034 Macro on, memory FFFC=00 and FFFD=C0. Required: reads of FFFC then FFFD, then an opcode read at C000; a 3-byte opcode at FFFE wraps its operand fetch to 0000.
